// File: rtl/ofmd_reader.sv
// ofmd_reader: walks the output-feature-map RAM after the convolution pass,
// applies ReLU + saturate to each word and streams bytes on valid/ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ofmd_rd_en          controller read-phase enable (level)
//   is_5x5              kernel size select, latched at frame start
//   ram_rd_en/addr      ofmd RAM read strobe and address
//   ram_rd_data         RAM word, valid one cycle after ram_rd_en
//   dout/dout_valid     output byte and its valid flag
//   dout_ready          downstream accepts dout this cycle
//   ofmd_rd_done        one-cycle pulse after the last byte is accepted
//   busy                high while reading or draining
//   clip_cnt            bytes clamped to 255 in the current/last frame
module ofmd_reader #(
    parameter int IMG_DIM = 16,
    parameter int DATA_W  = 20,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ofmd_rd_en,
    input  logic              is_5x5,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [7:0]        dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              ofmd_rd_done,
    output logic              busy,
    output logic [15:0]       clip_cnt
);

    localparam logic [ADDR_W-1:0] LAST_3X3 =
        ADDR_W'((IMG_DIM - 2) * (IMG_DIM - 2) - 1);
    localparam logic [ADDR_W-1:0] LAST_5X5 =
        ADDR_W'((IMG_DIM - 4) * (IMG_DIM - 4) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_q;
    logic              inflight_q;
    logic [1:0]        cnt_q;
    logic [7:0]        b0_q;
    logic [7:0]        b1_q;
    logic [15:0]       clip_q;
    logic              done_q;

    logic              start;
    logic              issue;
    logic              done_set;
    logic              push;
    logic              pop;
    logic [2:0]        level;
    logic [7:0]        cap_byte;
    logic              cap_clip;

    // A read returning this cycle is captured at the end of it, so the
    // in-flight flag doubles as the push strobe.
    assign push  = inflight_q;
    assign pop   = (cnt_q != 2'd0) && dout_ready;
    // Entries that will be held once this cycle's push/pop settle; a new
    // read may only be issued if its data is guaranteed a slot.
    assign level = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);

    assign ram_rd_en    = issue;
    assign ram_rd_addr  = addr_q;
    assign dout         = b0_q;
    assign dout_valid   = (cnt_q != 2'd0);
    assign ofmd_rd_done = done_q;
    assign busy         = (state_q == S_READ) || (state_q == S_DRAIN);
    assign clip_cnt     = clip_q;

    // ReLU + saturate on the incoming word.
    always_comb begin
        cap_byte = ram_rd_data[7:0];
        cap_clip = 1'b0;
        if (ram_rd_data[DATA_W-1]) begin
            cap_byte = 8'h00;
        end else if (|ram_rd_data[DATA_W-2:8]) begin
            cap_byte = 8'hFF;
            cap_clip = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        issue    = 1'b0;
        done_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ofmd_rd_en) begin
                    state_d = S_READ;
                    start   = 1'b1;
                end
            end
            S_READ: begin
                if (level < 3'd2) begin
                    issue = 1'b1;
                    if (addr_q == last_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && (cnt_q == 2'd1) && !inflight_q) begin
                    state_d  = S_DONE;
                    done_set = 1'b1;
                end
            end
            S_DONE: begin
                if (!ofmd_rd_en) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            b0_q       <= 8'h00;
            b1_q       <= 8'h00;
            clip_q     <= 16'h0000;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_set;
            inflight_q <= issue;

            if (start) begin
                addr_q <= '0;
                last_q <= is_5x5 ? LAST_5X5 : LAST_3X3;
            end else if (issue) begin
                addr_q <= addr_q + 1'b1;
            end

            if (start) begin
                clip_q <= 16'h0000;
            end else if (push && cap_clip && (clip_q != 16'hFFFF)) begin
                clip_q <= clip_q + 16'd1;
            end

            if (push && !pop) begin
                if (cnt_q == 2'd0) begin
                    b0_q <= cap_byte;
                end else begin
                    b1_q <= cap_byte;
                end
                cnt_q <= cnt_q + 2'd1;
            end else if (pop && !push) begin
                b0_q  <= b1_q;
                cnt_q <= cnt_q - 2'd1;
            end else if (push && pop) begin
                if (cnt_q == 2'd2) begin
                    b0_q <= b1_q;
                    b1_q <= cap_byte;
                end else begin
                    b0_q <= cap_byte;
                end
            end
        end
    end

endmodule
